// File: rtl/fp_addsub_unit.sv
// Multi-cycle IEEE-754 single-precision add/subtract with flush-to-zero and a valid/ready handshake.
// Define FPU_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results are truncated toward zero.
module fp_addsub_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       operation,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             errors
);

  localparam int unsigned MANT_W = 24;
  localparam int unsigned EXT_W  = 27;
  localparam int unsigned SUM_W  = 28;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_ALIGN  = 3'd2;
  localparam logic [2:0] S_ADD    = 3'd3;
  localparam logic [2:0] S_NORM   = 3'd4;
  localparam logic [2:0] S_ROUND  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

`ifdef FPU_ROUND_NEAREST_EN
  localparam bit ROUND_NEAREST = 1'b1;
`else
  localparam bit ROUND_NEAREST = 1'b0;
`endif

  logic [2:0]  r_state, w_state_nxt;
  logic        r_in_ready, r_out_valid, r_err;
  logic [WIDTH-1:0] r_out;

  logic [1:0]  r_op;
  logic [31:0] r_opa, r_opb;

  logic              r_sa, r_sb;
  logic [7:0]        r_ea, r_eb;
  logic [MANT_W-1:0] r_ma, r_mb;
  logic              r_spec, r_spec_err;
  logic [31:0]       r_spec_val;

  logic [EXT_W-1:0]  r_mbig, r_msmall;
  logic [7:0]        r_exp;
  logic              r_sign, r_sub;
  logic [SUM_W-1:0]  r_sum;
  logic [EXT_W-1:0]  r_nmant;
  logic signed [9:0] r_nexp;
  logic              r_zero;

  // Leading-zero count of a non-zero 27-bit magnitude.
  function automatic logic [4:0] lzc27(input logic [EXT_W-1:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < int'(EXT_W); i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (in_valid) w_state_nxt = S_UNPACK;
      S_UNPACK: w_state_nxt = S_ALIGN;
      S_ALIGN:  w_state_nxt = S_ADD;
      S_ADD:    w_state_nxt = S_NORM;
      S_NORM:   w_state_nxt = S_ROUND;
      S_ROUND:  w_state_nxt = S_DONE;
      S_DONE:   if (out_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
    end
  end

  // UNPACK: classify operands, flush subnormals, restore hidden bit.
  logic              w_sa, w_sb, w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic [7:0]        w_ea, w_eb;
  logic              w_spec, w_spec_err;
  logic [31:0]       w_spec_val;

  assign w_sa    = r_opa[31];
  assign w_sb    = r_opb[31] ^ r_op[0];
  assign w_ea    = r_opa[30:23];
  assign w_eb    = r_opb[30:23];
  assign w_a_nan = (w_ea == 8'hFF) && (r_opa[22:0] != 23'd0);
  assign w_b_nan = (w_eb == 8'hFF) && (r_opb[22:0] != 23'd0);
  assign w_a_inf = (w_ea == 8'hFF) && (r_opa[22:0] == 23'd0);
  assign w_b_inf = (w_eb == 8'hFF) && (r_opb[22:0] == 23'd0);

  always_comb begin
    w_spec     = 1'b0;
    w_spec_err = 1'b0;
    w_spec_val = 32'd0;
    if (r_op[1] || w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb))) begin
      w_spec     = 1'b1;
      w_spec_err = 1'b1;
      w_spec_val = QNAN;
    end else if (w_a_inf) begin
      w_spec     = 1'b1;
      w_spec_val = {w_sa, 8'hFF, 23'd0};
    end else if (w_b_inf) begin
      w_spec     = 1'b1;
      w_spec_val = {w_sb, 8'hFF, 23'd0};
    end
  end

  // ALIGN: order by magnitude and shift the smaller significand with sticky collection.
  logic              w_a_ge;
  logic [7:0]        w_diff, w_ebig;
  logic [MANT_W-1:0] w_mbig_u, w_msmall_u;
  logic [EXT_W-1:0]  w_small_ext, w_shifted, w_small_al;
  logic              w_lost;

  assign w_a_ge      = {r_ea, r_ma} >= {r_eb, r_mb};
  assign w_ebig      = w_a_ge ? r_ea : r_eb;
  assign w_diff      = w_a_ge ? (r_ea - r_eb) : (r_eb - r_ea);
  assign w_mbig_u    = w_a_ge ? r_ma : r_mb;
  assign w_msmall_u  = w_a_ge ? r_mb : r_ma;
  assign w_small_ext = {w_msmall_u, 3'b000};
  assign w_shifted   = w_small_ext >> w_diff;
  assign w_lost      = |(w_small_ext & ~(27'h7FF_FFFF << w_diff));

  always_comb begin
    w_small_al = {w_shifted[EXT_W-1:1], w_shifted[0] | w_lost};
    if (w_diff >= 8'd27) w_small_al = {26'd0, |w_msmall_u};
  end

  // NORM: carry-out right shift or leading-zero left shift.
  logic [4:0]        w_lz;
  logic [EXT_W-1:0]  w_nmant;
  logic signed [9:0] w_nexp;

  assign w_lz = lzc27(r_sum[EXT_W-1:0]);

  always_comb begin
    w_nmant = r_sum[EXT_W-1:0] << w_lz;
    w_nexp  = signed'({2'b00, r_exp}) - signed'({5'b00000, w_lz});
    if (r_sum[SUM_W-1]) begin
      w_nmant = {r_sum[SUM_W-1:2], r_sum[1] | r_sum[0]};
      w_nexp  = signed'({2'b00, r_exp}) + 10'sd1;
    end
  end

  // ROUND: optional nearest-even increment, then range checks and result packing.
  logic              w_rnd_up;
  logic [MANT_W:0]   w_mant_r;
  logic [22:0]       w_frac;
  logic signed [9:0] w_exp_f;
  logic [31:0]       w_result;
  logic              w_result_err;

  assign w_rnd_up = ROUND_NEAREST & r_nmant[2] & (r_nmant[1] | r_nmant[0] | r_nmant[3]);
  assign w_mant_r = {1'b0, r_nmant[EXT_W-1:3]} + 25'(w_rnd_up);
  assign w_frac   = w_mant_r[MANT_W] ? w_mant_r[23:1] : w_mant_r[22:0];
  assign w_exp_f  = r_nexp + signed'({9'd0, w_mant_r[MANT_W]});

  always_comb begin
    w_result     = {r_sign, w_exp_f[7:0], w_frac};
    w_result_err = 1'b0;
    if (r_spec) begin
      w_result     = r_spec_val;
      w_result_err = r_spec_err;
    end else if (r_zero) begin
      w_result = {r_sign & ~r_sub, 31'd0};
    end else if (w_exp_f <= 10'sd0) begin
      w_result = {r_sign, 31'd0};
    end else if (w_exp_f >= 10'sd255) begin
      w_result     = {r_sign, 8'hFF, 23'd0};
      w_result_err = 1'b1;
    end
  end

  // Datapath registers, each stage loaded only in its own state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= 2'd0;
      r_opa      <= 32'd0;
      r_opb      <= 32'd0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_ea       <= 8'd0;
      r_eb       <= 8'd0;
      r_ma       <= '0;
      r_mb       <= '0;
      r_spec     <= 1'b0;
      r_spec_err <= 1'b0;
      r_spec_val <= 32'd0;
      r_mbig     <= '0;
      r_msmall   <= '0;
      r_exp      <= 8'd0;
      r_sign     <= 1'b0;
      r_sub      <= 1'b0;
      r_sum      <= '0;
      r_nmant    <= '0;
      r_nexp     <= 10'sd0;
      r_zero     <= 1'b0;
      r_out      <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_op  <= operation;
          r_opa <= 32'(opa);
          r_opb <= 32'(opb);
        end
        S_UNPACK: begin
          r_sa       <= w_sa;
          r_sb       <= w_sb;
          r_ea       <= (w_ea == 8'd0) ? 8'd0 : w_ea;
          r_eb       <= (w_eb == 8'd0) ? 8'd0 : w_eb;
          r_ma       <= (w_ea == 8'd0) ? 24'd0 : {1'b1, r_opa[22:0]};
          r_mb       <= (w_eb == 8'd0) ? 24'd0 : {1'b1, r_opb[22:0]};
          r_spec     <= w_spec;
          r_spec_err <= w_spec_err;
          r_spec_val <= w_spec_val;
        end
        S_ALIGN: begin
          r_mbig   <= {w_mbig_u, 3'b000};
          r_msmall <= w_small_al;
          r_exp    <= w_ebig;
          r_sign   <= w_a_ge ? r_sa : r_sb;
          r_sub    <= r_sa ^ r_sb;
        end
        S_ADD: begin
          r_sum <= r_sub ? ({1'b0, r_mbig} - {1'b0, r_msmall})
                         : ({1'b0, r_mbig} + {1'b0, r_msmall});
        end
        S_NORM: begin
          r_nmant <= w_nmant;
          r_nexp  <= w_nexp;
          r_zero  <= (r_sum == '0);
        end
        S_ROUND: begin
          r_out <= WIDTH'(w_result);
          r_err <= w_result_err;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign errors    = r_err;

endmodule

// File: tb/tb_fp_addsub_unit.sv
// Directed bench for fp_addsub_unit: hand-computed vectors, handshake stall and mid-operation reset.
module tb_fp_addsub_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  operation;
  logic [31:0] opa, opb;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_val;
  logic        err_flag;

  int n_chk = 0;
  int n_err = 0;

  fp_addsub_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .opa       (opa),
    .opb       (opb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_val),
    .errors    (err_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FPU_ROUND_NEAREST_EN
  localparam logic [31:0] EXP_TINY_ADD  = 32'h3F80_0001;
  localparam logic [31:0] EXP_ROUND_CRY = 32'h4000_0000;
`else
  localparam logic [31:0] EXP_TINY_ADD  = 32'h3F80_0000;
  localparam logic [31:0] EXP_ROUND_CRY = 32'h3FFF_FFFF;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Issue one request, time the result (accepting edge counts as edge 1), check and retire it.
  task automatic do_op(input string tag, input bit sync, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_out, input logic exp_err);
    int n;
    if (sync) @(negedge clk);
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    operation = op;
    opa       = a;
    opb       = b;
    in_valid  = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({tag, "_lat"}, 32'(n), 32'd6);
    check({tag, "_out"}, out_val, exp_out);
    check({tag, "_err"}, 32'(err_flag), 32'(exp_err));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ret"}, 32'(out_valid), 32'd0);
  endtask

  typedef struct {
    string       tag;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int n;
    int stale;
    logic [31:0] held;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    operation = 2'd0;
    opa       = 32'd0;
    opb       = 32'd0;
    out_ready = 1'b0;

    #12;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out",       out_val,        32'd0);
    check("rst_errors",    32'(err_flag),  32'd0);

    vecs.push_back('{"add_4_214",   2'b00, 32'h4080_0000, 32'h4356_0000, 32'h435A_0000, 1'b0});
    vecs.push_back('{"sub_1_1",     2'b01, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0});
    vecs.push_back('{"inf_m_inf",   2'b00, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b1});
    vecs.push_back('{"ovf",         2'b00, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b1});
    vecs.push_back('{"tiny_add",    2'b00, 32'h3F80_0000, 32'h33C0_0000, EXP_TINY_ADD,  1'b0});
    vecs.push_back('{"rnd_carry",   2'b00, 32'h3FFF_FFFF, 32'h3380_0000, EXP_ROUND_CRY, 1'b0});
    vecs.push_back('{"tie_even",    2'b00, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 1'b0});
    vecs.push_back('{"sub_1_2",     2'b01, 32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 1'b0});
    vecs.push_back('{"nz_p_nz",     2'b00, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0});
    vecs.push_back('{"nz_m_pz",     2'b01, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0});
    vecs.push_back('{"pz_p_nz",     2'b00, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0});
    vecs.push_back('{"nan_in",      2'b00, 32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b1});
    vecs.push_back('{"bad_op",      2'b10, 32'h3F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b1});
    vecs.push_back('{"inf_p_1",     2'b00, 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 1'b0});
    vecs.push_back('{"1_m_inf",     2'b01, 32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000, 1'b0});
    vecs.push_back('{"inf_m_ninf",  2'b01, 32'h7F80_0000, 32'hFF80_0000, 32'h7F80_0000, 1'b0});
    vecs.push_back('{"sub_flush",   2'b00, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0});
    vecs.push_back('{"sub_p_1",     2'b00, 32'h0040_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0});
    vecs.push_back('{"underflow",   2'b01, 32'h0080_0000, 32'h0080_0001, 32'h8000_0000, 1'b0});
    vecs.push_back('{"carry_norm",  2'b00, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4040_0000, 1'b0});

    // First request lands on the first edge after reset release.
    @(negedge clk);
    #1 rst_n = 1'b1;
    do_op("first_after_rst", 1'b0, 2'b00, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0);

    foreach (vecs[i])
      do_op(vecs[i].tag, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err);

    // Back-pressure: result held for three refused edges, retired on the fourth.
    @(negedge clk);
    operation = 2'b00;
    opa       = 32'h4080_0000;
    opb       = 32'h4356_0000;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("stall_lat", 32'(n), 32'd6);
    held = out_val;
    check("stall_val", held, 32'h435A_0000);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("stall_out_%0d", k),   out_val,            held);
      check($sformatf("stall_valid_%0d", k), 32'(out_valid),     32'd1);
      check($sformatf("stall_rdy_%0d", k),   32'(in_ready),      32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("stall_retired", 32'(out_valid), 32'd0);
    check("stall_in_ready", 32'(in_ready), 32'd1);

    // Reset asserted while the operation sits in ALIGN.
    operation = 2'b00;
    opa       = 32'h3FC0_0000;
    opb       = 32'h3FC0_0000;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'd1);
    check("mid_rst_out",   out_val,        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("mid_rst_stale", 32'(stale), 32'd0);
    check("mid_rst_idle",  32'(in_ready), 32'd1);

    do_op("post_rst", 1'b1, 2'b01, 32'h4356_0000, 32'h4080_0000, 32'h4352_0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp_addsub_unit.md
FP_ADDSUB_UNIT -- requirements
Module: fp_addsub_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; 32 (IEEE-754 single) is the only legal value.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  request carries a valid operation/opa/opb.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port operation  input  2  00 add, 01 subtract (opa-opb), 10/11 invalid.
REQ-007 SHALL have port opa  input  32  first operand.
REQ-008 SHALL have port opb  input  32  second operand.
REQ-009 SHALL have port out_valid  output  1  out/errors hold a result.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out  output  32  result.
REQ-012 SHALL have port errors  output  1  result is exceptional (NaN, overflow, invalid op).

Function
REQ-013 SHALL accept a request on a rising edge with in_valid=1 and in_ready=1, registering operation, opa and opb.
REQ-014 SHALL drive in_ready=1 only in state IDLE.
REQ-015 SHALL step through IDLE->UNPACK->ALIGN->ADD->NORM->ROUND->DONE, one state per cycle, no stalls before DONE.
REQ-016 SHALL assert out_valid in DONE, exactly 6 rising edges after the accepting edge.
REQ-017 SHALL hold out, errors and out_valid stable in DONE until an edge with out_ready=1, then return to IDLE.
REQ-018 SHALL not accept a new request in the same edge that retires a result; next acceptance is earliest one cycle later.
REQ-019 SHALL in UNPACK flush subnormal inputs to signed zero and restore the hidden bit on normal inputs.
REQ-020 SHALL in ALIGN right-shift the smaller-exponent significand by the exponent difference, keeping guard, round and sticky bits; shifts >=27 leave only sticky.
REQ-021 SHALL in ADD add or subtract magnitudes per effective sign (operation XOR sign bits) with a 28-bit datapath.
REQ-022 SHALL in NORM left-normalise via leading-zero count, or right-shift by one on carry-out, adjusting exponent accordingly.
REQ-023 SHALL produce +0 for exact-zero results, except (-0)+(-0) and (-0)-(+0) which give -0.
REQ-024 SHALL flush results whose exponent underflows to signed zero with errors=0.
REQ-025 SHALL on exponent overflow give signed infinity (0x7F800000 / 0xFF800000) with errors=1.
REQ-026 SHALL give 0x7FC00000 with errors=1 for any NaN input, inf-inf effective subtraction, or operation 10/11.
REQ-027 SHALL pass infinity through (sign of the infinite operand) with errors=0 when only one operand is infinite or both agree.

Reset
REQ-028 SHALL on rst_n=0 immediately force state IDLE, in_ready=1, out_valid=0, out=0, errors=0, regardless of operation in progress.
REQ-029 SHALL discard any in-flight operation on reset; no result from it ever appears.
REQ-030 SHALL accept a request on the first rising edge after rst_n deasserts.

Configuration
REQ-031 SHALL, with macro FPU_ROUND_NEAREST_EN defined, apply round-to-nearest-even in ROUND using guard/round/sticky, including re-normalisation on mantissa carry-out.
REQ-032 SHALL, without FPU_ROUND_NEAREST_EN, truncate (round toward zero) in ROUND; latency identical.

Verification
REQ-033 SHALL cover add 0x40800000 + 0x43560000 (4.0+214.0) -> out=0x435A0000, errors=0, out_valid 6 edges after acceptance.
REQ-034 SHALL cover sub 0x3F800000 - 0x3F800000 -> out=0x00000000, errors=0.
REQ-035 SHALL cover add 0x7F800000 + 0xFF800000 -> out=0x7FC00000, errors=1; add 0x7F7FFFFF + 0x7F7FFFFF -> out=0x7F800000, errors=1.
REQ-036 SHALL cover add 0x3F800000 + 0x33C00000 -> out=0x3F800001 with FPU_ROUND_NEAREST_EN, 0x3F800000 without.
REQ-037 SHALL cover out_ready held 0 for 3 cycles in DONE -> out/out_valid stable, in_ready=0, retire on 4th edge, in_ready=1 next cycle.
REQ-038 SHALL cover rst_n pulsed low during ALIGN -> out_valid=0 and in_ready=1 immediately; no stale result after reset release.
